// File: rtl/dk_sound_pkg.sv
// dk_sound_pkg
//   Shared definitions for the discrete sound-effect audio path.
//   - SAMPLE_W / GAIN_W / GAIN_UNITY : sample and gain formats
//     (signed 16-bit samples, unsigned Q1.7 gains, 128 == unity).
//   - sample_t                      : signed audio sample type.
//   - mix_state_e                   : state encoding of the mixer FSM.
//   - sat16()                       : clip a wide signed value to 16 bits.
package dk_sound_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 8;
  localparam int GAIN_UNITY = 128;

  // Signed sample times unsigned gain: the gain is widened by one zero bit
  // so the multiply stays signed, giving a 25-bit product.
  localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;

  // Widest value sat16 accepts.
  localparam int SAT_IN_W   = 48;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [GAIN_W-1:0]          gain_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2
  } mix_state_e;

  function automatic sample_t sat16(input logic signed [SAT_IN_W-1:0] x);
    if (x > 48'sd32767) begin
      return 16'sh7fff;
    end else if (x < -48'sd32768) begin
      return 16'sh8000;
    end else begin
      return sample_t'(x[SAMPLE_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/signed_saturator.sv
// signed_saturator
//   Combinational arithmetic right shift (floor, toward -inf) followed by
//   clipping to a signed 16-bit sample.
//   Parameters:
//     IN_W  : width of the signed input (at most 48).
//     SHIFT : number of bits to shift right before clipping.
//   Ports:
//     din   in  IN_W, signed : wide value to scale and clip.
//     dout  out 16,   signed : clipped sample.
module signed_saturator
  import dk_sound_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0] din,
  output sample_t                dout
);

  logic signed [IN_W-1:0]     shifted;
  logic signed [SAT_IN_W-1:0] wide;

  // >>> on a signed operand replicates the sign bit, which is floor division.
  assign shifted = din >>> SHIFT;
  assign wide    = SAT_IN_W'(shifted);
  assign dout    = sat16(wide);

endmodule

// File: rtl/dk_sound_mixer.sv
// dk_sound_mixer
//   Time-multiplexed saturating mixer for the discrete sound-effect voices.
//   On each audio_clk_en strobe the voice samples, gains and enables are
//   snapshotted, then one lane per clk is multiplied and accumulated through a
//   single shared MAC. The sum is scaled by 2^-(7+OUT_SHIFT), clipped to
//   16 bits and registered onto out.
//
//   Parameters:
//     NUM_VOICES : number of lanes, 1..16.
//     OUT_SHIFT  : extra right shift before saturation, 0..4.
//   Ports:
//     clk           in  1             : system clock.
//     reset_n       in  1             : asynchronous active-low reset.
//     audio_clk_en  in  1             : one-cycle sample strobe.
//     voices[]      in  16 signed     : voice samples.
//     gains[]       in  8 unsigned    : Q1.7 gains (128 == unity).
//     voice_enable  in  NUM_VOICES    : per-lane enable.
//     out           out 16 signed     : mixed sample, held between updates.
//     out_valid     out 1             : one-cycle pulse when out updates.
//     overrun       out 1             : sticky, strobe seen while mixing.
//     state_dbg     out 2             : current FSM state (mix_state_e).
//
//   Output handshake: out_valid is a push-only qualifier with no ready.
//   out is meaningful in the cycle out_valid is high and keeps that value
//   until the next pulse; a consumer that is not ready simply misses it.
//   Strobes are accepted only in IDLE; a strobe in ACCUM or FINISH is dropped
//   and latches overrun.
//
//   Timing: strobe sampled in cycle T, lane i accumulated in T+1+i, FINISH in
//   T+NUM_VOICES+1, out/out_valid visible in T+NUM_VOICES+2.
module dk_sound_mixer
  import dk_sound_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  audio_clk_en,
  input  logic signed [15:0]    voices [NUM_VOICES],
  input  logic [7:0]            gains [NUM_VOICES],
  input  logic [NUM_VOICES-1:0] voice_enable,
  output logic signed [15:0]    out,
  output logic                  out_valid,
  output logic                  overrun,
  output logic [1:0]            state_dbg
);

  // Enough headroom that NUM_VOICES full-scale products can never overflow.
  localparam int ACC_W = PROD_W + $clog2(NUM_VOICES);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  mix_state_e state;
  mix_state_e state_nxt;

  sample_t                 hold_voices [NUM_VOICES];
  gain_t                   hold_gains  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   hold_en;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;

  // Control decoded from the state
  logic snap;
  logic acc_step;
  logic load_out;
  logic flag_overrun;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (audio_clk_en) begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (idx == LAST_IDX) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    snap         = 1'b0;
    acc_step     = 1'b0;
    load_out     = 1'b0;
    flag_overrun = 1'b0;
    case (state)
      ST_IDLE: begin
        snap = audio_clk_en;
      end
      ST_ACCUM: begin
        acc_step     = 1'b1;
        flag_overrun = audio_clk_en;
      end
      ST_FINISH: begin
        load_out     = 1'b1;
        flag_overrun = audio_clk_en;
      end
      default: begin
        snap = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // Shared multiply-accumulate lane term
  // ---------------------------------------------------------------------
  logic signed [GAIN_W:0]   gain_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  lane_term;

  // Zero-extend the unsigned gain into a signed operand so the whole
  // multiply is signed; both operands are widened to the product width
  // with sign extension before multiplying.
  assign gain_s    = {1'b0, hold_gains[idx]};
  assign prod      = PROD_W'(hold_voices[idx]) * PROD_W'(gain_s);
  assign lane_term = hold_en[idx] ? ACC_W'(prod) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        hold_voices[i] <= '0;
        hold_gains[i]  <= '0;
      end
      hold_en <= '0;
      acc     <= '0;
      idx     <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        hold_voices[i] <= voices[i];
        hold_gains[i]  <= gains[i];
      end
      hold_en <= voice_enable;
      acc     <= '0;
      idx     <= '0;
    end else if (acc_step) begin
      acc <= acc + lane_term;
      idx <= idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Scale, clip and register the result
  // ---------------------------------------------------------------------
  sample_t sat_out;

  signed_saturator #(
    .IN_W  (ACC_W),
    .SHIFT (7 + OUT_SHIFT)
  ) u_sat (
    .din  (acc),
    .dout (sat_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= load_out;
      if (load_out) begin
        out <= sat_out;
      end
      if (flag_overrun) begin
        overrun <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // FINISH lasts a single cycle and is always followed by IDLE, so a valid
  // pulse can never be extended.
  a_valid_pulse : assert property (@(posedge clk) disable iff (!reset_n)
    out_valid |=> !out_valid);
`endif

endmodule

// File: tb/tb_dk_sound_mixer.sv
module tb_dk_sound_mixer;

  localparam int NV  = 4;
  localparam int LAT = NV + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic audio_clk_en;
  logic signed [15:0] voices [NV];
  logic [7:0]         gains  [NV];
  logic [NV-1:0]      voice_enable;

  logic signed [15:0] out0, out2;
  logic               out_valid0, out_valid2;
  logic               overrun0, overrun2;
  logic [1:0]         state_dbg0, state_dbg2;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dk_sound_mixer #(.NUM_VOICES(NV), .OUT_SHIFT(0)) dut0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_clk_en (audio_clk_en),
    .voices       (voices),
    .gains        (gains),
    .voice_enable (voice_enable),
    .out          (out0),
    .out_valid    (out_valid0),
    .overrun      (overrun0),
    .state_dbg    (state_dbg0)
  );

  dk_sound_mixer #(.NUM_VOICES(NV), .OUT_SHIFT(2)) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_clk_en (audio_clk_en),
    .voices       (voices),
    .gains        (gains),
    .voice_enable (voice_enable),
    .out          (out2),
    .out_valid    (out_valid2),
    .overrun      (overrun2),
    .state_dbg    (state_dbg2)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  // {strobe cycle[63:32], expected shift-2 out[31:16], expected shift-0 out[15:0]}
  logic [63:0] exp_q[$];
  logic signed [15:0] last0 = 16'sd0;
  logic signed [15:0] last2 = 16'sd0;
  int   last_t  = -1000;
  logic exp_ovr = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: sum of enabled voice*gain products, divided by 2^(7+sh)
  // rounding toward -inf, then clamped to the 16-bit range.
  function automatic logic signed [15:0] mix_model(input int sh);
    longint s, d, q;
    s = 0;
    for (int i = 0; i < NV; i++) begin
      if (voice_enable[i]) s += longint'(voices[i]) * longint'(gains[i]);
    end
    d = longint'(1) << (7 + sh);
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int v0, input int v1, input int v2, input int v3,
                        input int g0, input int g1, input int g2, input int g3,
                        input logic [3:0] en);
    voices[0] = 16'(v0); voices[1] = 16'(v1);
    voices[2] = 16'(v2); voices[3] = 16'(v3);
    gains[0]  = 8'(g0);  gains[1]  = 8'(g1);
    gains[2]  = 8'(g2);  gains[3]  = 8'(g3);
    voice_enable = en;
  endtask

  // Raise the strobe for the current cycle; the model decides whether the
  // mixer is free (a full LAT cycles since the last accepted strobe).
  task automatic strobe();
    logic signed [15:0] e0, e2;
    audio_clk_en = 1'b1;
    if (cyc - last_t >= LAT) begin
      e0 = mix_model(0);
      e2 = mix_model(2);
      exp_q.push_back({32'(cyc), 16'(e2), 16'(e0)});
      last_t = cyc;
    end else begin
      exp_ovr = 1'b1;
    end
    tick(1);
    audio_clk_en = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 50) begin
      tick(1);
      b++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    exp_q.delete();
    last0   = 16'sd0;
    last2   = 16'sd0;
    last_t  = -1000;
    exp_ovr = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset_n) begin
      if (out_valid0 || out_valid2) begin
        check("valid_pair", int'(out_valid2), int'(out_valid0));
        check("valid_not_back_to_back", int'(prev_valid), 0);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: got out=%0d with no pending mix", out0);
        end else begin
          e = exp_q.pop_front();
          check("out_shift0", int'(out0), int'($signed(e[15:0])));
          check("out_shift2", int'(out2), int'($signed(e[31:16])));
          check("latency", cyc - int'(e[63:32]), LAT);
          check("overrun_at_valid", int'(overrun0), int'(exp_ovr));
          check("overrun_at_valid_s2", int'(overrun2), int'(exp_ovr));
          last0 = $signed(e[15:0]);
          last2 = $signed(e[31:16]);
        end
      end else begin
        check("out_hold0", int'(out0), int'(last0));
        check("out_hold2", int'(out2), int'(last2));
      end
      prev_valid = out_valid0;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    audio_clk_en = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    apply_reset();
    tick(3);
    check("reset_out", int'(out0), 0);
    check("reset_valid", int'(out_valid0), 0);
    check("reset_overrun", int'(overrun0), 0);
    check("reset_state", int'(state_dbg0), 0);
    reset_n = 1'b1;
    tick(2);

    // unity sum
    set_in(1000, 2000, 0, 0, 128, 128, 128, 128, 4'b1111);
    strobe(); wait_idle();
    // positive and negative saturation
    set_in(30000, 30000, 0, 0, 128, 128, 128, 128, 4'b1111);
    strobe(); wait_idle();
    set_in(-30000, -30000, -30000, 0, 128, 128, 128, 128, 4'b1111);
    strobe(); wait_idle();
    // floor rounding and maximum gain
    set_in(-1, 0, 0, 0, 64, 128, 128, 128, 4'b1111);
    strobe(); wait_idle();
    set_in(1000, 0, 0, 0, 255, 128, 128, 128, 4'b1111);
    strobe(); wait_idle();
    // snapshot: change voice0 the cycle after the strobe
    set_in(5000, 0, 0, 0, 128, 128, 128, 128, 4'b1111);
    strobe();
    voices[0] = 16'sd9000;
    wait_idle();
    // disabled lane contributes nothing
    set_in(5000, 0, 0, 0, 128, 128, 128, 128, 4'b1110);
    strobe(); wait_idle();

    // overrun: second strobe 3 cycles after the first is dropped
    set_in(1234, -200, 300, 7, 128, 200, 64, 255, 4'b1111);
    strobe();
    tick(2);
    set_in(-7000, 0, 0, 0, 128, 128, 128, 128, 4'b1111);
    strobe();
    check("overrun_set", int'(overrun0), 1);
    wait_idle();
    check("overrun_sticky", int'(overrun0), 1);
    set_in(-700, 100, 0, 0, 128, 128, 128, 128, 4'b1111);
    strobe(); wait_idle();

    // reset in the middle of ACCUM
    set_in(4000, 4000, 4000, 4000, 128, 128, 128, 128, 4'b1111);
    strobe();
    tick(1);
    apply_reset();
    #1;
    check("midreset_out", int'(out0), 0);
    check("midreset_valid", int'(out_valid0), 0);
    check("midreset_overrun", int'(overrun0), 0);
    check("midreset_state", int'(state_dbg0), 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    set_in(-1500, 2500, 100, -3, 100, 50, 255, 1, 4'b1011);
    strobe(); wait_idle();

    // randomized mixes on legal strobe periods
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NV; i++) begin
        voices[i] = 16'($urandom_range(0, 65535));
        gains[i]  = 8'($urandom_range(0, 255));
      end
      voice_enable = 4'($urandom_range(0, 15));
      strobe();
      wait_idle();
      tick($urandom_range(0, 3));
    end
    check("final_overrun", int'(overrun0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
